// File: rtl/ecc_pkg.sv
// Shared secp256k1 field definitions: field width, prime, and the modular-multiplier state type.
package ecc_pkg;

  localparam int unsigned FIELD_W = 256;

  localparam logic [FIELD_W-1:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational (x + y) mod p for x, y < p; one conditional subtract on a 257-bit sum.
module mod_add
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = FIELD_W
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, x_i} + {1'b0, y_i};
    diff = sum - {1'b0, SECP256K1_P};
    r_o  = (sum >= {1'b0, SECP256K1_P}) ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_mul.sv
// Sequential secp256k1 modular multiplier, MSB-first interleaved double-and-add, one bit of B per cycle.
// Optional MOD_MUL_BUSY_EN adds a busy output (high in RUN and DONE).
module mod_mul
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = FIELD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
`ifdef MOD_MUL_BUSY_EN
  output logic             busy,
`endif
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_red;
  logic [WIDTH-1:0] dbl;
  logic [WIDTH-1:0] dbl_add;

  // A < 2^256 < 2p, so one conditional subtract fully reduces it.
  assign a_red = (A >= SECP256K1_P) ? (A - SECP256K1_P) : A;

  mod_add #(.WIDTH(WIDTH)) u_dbl (
    .x_i (acc_q),
    .y_i (acc_q),
    .r_o (dbl)
  );

  mod_add #(.WIDTH(WIDTH)) u_add (
    .x_i (dbl),
    .y_i (a_q),
    .r_o (dbl_add)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_red;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = 8'd255;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = b_q[cnt_q] ? dbl_add : dbl;
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        r_d     = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign R    = r_q;
  assign done = done_q;

`ifdef MOD_MUL_BUSY_EN
  assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul: scoreboard of expected products, latency and done-pulse checks.
module tb_mod_mul;

  localparam logic [255:0] PT =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int LAT = 257;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] A;
  logic [255:0] B;
  logic [255:0] R;
  logic         done;
`ifdef MOD_MUL_BUSY_EN
  logic         busy;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] exp_q[$];
  logic [255:0] last_r;

  mod_mul #(.WIDTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .R     (R),
`ifdef MOD_MUL_BUSY_EN
    .busy  (busy),
`endif
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    logic [511:0] rem;
    prod = {256'b0, a} * {256'b0, b};
    rem  = prod % {256'b0, PT};
    return rem[255:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int unsigned k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive a one-cycle start; returns #1 after the accepting edge with inputs scrambled.
  task automatic start_op(input logic [255:0] a, input logic [255:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = rnd256();
    B     = rnd256();
  endtask

  // Bounded wait for done; edges = -1 on timeout.
  task automatic wait_done(output int edges, output logic [255:0] r);
    edges = -1;
    r     = '0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = e;
        r     = R;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (R !== 256'd0) begin
      n_bad++;
      $display("FAIL reset_R: got %h want 0", R);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    last_r = '0;
  endtask

  task automatic run_and_check(input logic [255:0] a, input logic [255:0] b,
                               input logic [255:0] expv, input string name);
    int           edges;
    logic [255:0] r;
    logic [255:0] want;
    exp_q.push_back(expv);
    start_op(a, b);
    wait_done(edges, r);
    want = exp_q.pop_front();
    n_cmp++;
    if (edges != LAT) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, edges, LAT);
    end
    n_cmp++;
    if (r !== want) begin
      n_bad++;
      $display("FAIL %s_R: got %h want %h", name, r, want);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_pulse: done still %b one cycle later, want 0", name, done);
    end
    last_r = want;
  endtask

  task automatic test_vectors();
    run_and_check(256'd0, 256'd0, 256'd0, "zero");
    run_and_check(256'd1, 256'd1, 256'd1, "one");
    run_and_check(256'd2, 256'd3, 256'd6, "two_three");
    run_and_check(PT - 256'd1, 256'd2, PT - 256'd2, "pm1_x2");
    run_and_check(PT - 256'd2, PT - 256'd3, 256'd6, "pm2_pm3");
    run_and_check(256'h12345, 256'hFED, 256'h121EB1E1, "small");
    run_and_check(PT + 256'd5, 256'd1, 256'd5, "unreduced_a");
  endtask

  task automatic test_random();
    logic [255:0] a;
    logic [255:0] b;
    for (int unsigned k = 0; k < 4; k++) begin
      a = rnd256();
      b = rnd256();
      if (k == 0) a = '1;
      run_and_check(a, b, ref_mul(a, b), "random");
    end
  endtask

  task automatic test_ignore_start();
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] want;
    logic [255:0] prev;
    int           early;
    int           extra;
    a    = rnd256();
    b    = rnd256();
    prev = last_r;
    exp_q.push_back(ref_mul(a, b));
    start_op(a, b);
    early = 0;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk);
      #1;
      if (e < LAT && done === 1'b1) early++;
      if (e == 1) begin
        n_cmp++;
        if (R !== prev) begin
          n_bad++;
          $display("FAIL hold_R: got %h want %h", R, prev);
        end
`ifdef MOD_MUL_BUSY_EN
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_run: got %b want 1", busy);
        end
`endif
      end
      if (e == 99 || e == 256) begin
        start = 1'b1;
        A     = 256'd7;
        B     = 256'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    want  = exp_q.pop_front();
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL ignore_early: got %0d early done pulses want 0", early);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_done: got %b want 1 at edge %0d", done, LAT);
    end
    n_cmp++;
    if (R !== want) begin
      n_bad++;
      $display("FAIL ignore_R: got %h want %h", R, want);
    end
    extra = 0;
    for (int e = 0; e < 300; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL ignore_queued: got %0d done pulses want 0", extra);
    end
    n_cmp++;
    if (R !== want) begin
      n_bad++;
      $display("FAIL ignore_R_hold: got %h want %h", R, want);
    end
    last_r = want;
  endtask

  task automatic test_reset_abort();
    int extra;
    start_op(rnd256(), rnd256());
    repeat (120) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (R !== 256'd0) begin
      n_bad++;
      $display("FAIL abort_R: got %h want 0", R);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_done: got %b want 0", done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    extra = 0;
    for (int e = 0; e < 300; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", extra);
    end
    n_cmp++;
    if (R !== 256'd0) begin
      n_bad++;
      $display("FAIL abort_R_after: got %h want 0", R);
    end
    last_r = '0;
  endtask

  task automatic test_back_to_back();
    logic [255:0] a;
    logic [255:0] b;
    a = rnd256();
    b = rnd256();
    run_and_check(a, b, ref_mul(a, b), "after_abort");
    run_and_check(b, a, ref_mul(a, b), "commute");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
